clock_monitor: RTL and testbench
================================

Name: clock_monitor

Overview:
- Measures the frequency of a divided monitor clock, such as the primary or auxiliary monitor output of the clock router, against the local core clock.
- Counts synchronized rising edges of the monitored clock over a programmable window of core_clk cycles.
- Flags a missing clock, counter saturation, and out-of-range results.
- Sits on the core_clk domain; results are read by the housekeeping/status logic.

Parameters:
- CNT_WIDTH, 16, width of the edge counter and of the count/min/max ports
- WIN_WIDTH, 16, width of the window length input
- ARM_TIMEOUT, 1024, core_clk cycles to wait for the first monitored edge before declaring no clock

Ports:
- core_clk  input  1  block clock
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a measurement
- mon_clk  input  1  monitored clock, asynchronous to core_clk
- window  input  WIN_WIDTH  measurement window length in core_clk cycles
- min_count  input  CNT_WIDTH  lower acceptable bound (inclusive)
- max_count  input  CNT_WIDTH  upper acceptable bound (inclusive)
- count  output  CNT_WIDTH  rising edges counted in the last window
- valid  output  1  one-cycle pulse when a result is published
- busy  output  1  high from accepted start through the DONE state
- overflow  output  1  counter saturated during the last measurement
- no_clock  output  1  last measurement timed out in ARM
- out_of_range  output  1  last result is below min_count, above max_count, or overflowed

Behaviour:
- Interface decision: one clock (core_clk); reset is synchronous and active-high (reset).
- Reset:
  - All outputs 0, FSM in IDLE.
  - Synchronizer flops 0; timers and counter 0.
  - Reset asserted in any state aborts the measurement; no valid pulse is produced.
- Synchronizer:
  - mon_clk passes through two flops (s1, s2) plus a history flop s3.
  - Edge pulse = s2 & ~s3.
  - Latency is 3 core_clk cycles from a mon_clk rise to the edge pulse.
  - Accuracy is guaranteed only for mon_clk frequency below core_clk/2; faster inputs undercount (not checked).
- FSM states: IDLE, ARM, COUNT, DONE.
- IDLE:
  - busy=0.
  - start=1 with window!=0: latch window, clear the counter and the arm timer, go to ARM, busy=1 from the next cycle.
  - start with window==0 is ignored.
  - count and flags hold their previous values.
- ARM (aligns the window to a monitored edge):
  - The arm timer increments every cycle.
  - On an edge pulse: go to COUNT and load the window timer with the latched window. The arming edge is not counted.
  - If the arm timer reaches ARM_TIMEOUT-1 with no edge: go to DONE with no_clock=1, count=0, overflow=0.
- COUNT:
  - Lasts exactly window cycles.
  - Each cycle: decrement the window timer; an edge pulse in that cycle increments the counter.
  - An edge in the final cycle is counted.
  - The counter saturates at all-ones; an increment attempted at saturation sets an internal overflow flag.
  - When the timer decrements from 1 to 0: go to DONE.
- DONE (exactly one cycle):
  - Publish count, overflow and no_clock; valid=1 in this cycle.
  - out_of_range = overflow | no_clock | (count<min_count) | (count>max_count), using min/max sampled in DONE.
  - Next state is IDLE.
  - busy is high in DONE and low in the following cycle.
- start while busy (ARM, COUNT, DONE) is ignored; it is not queued.
- Published results hold until the next DONE or reset. They are not cleared by a new start.
- min_count > max_count is not checked; the compare is then always true.
- Arithmetic is unsigned throughout.

Test Plan:
- Reset, then mon_clk period 8 core_clk cycles, window=800, start -> valid after the arming edge plus 801 cycles; count=100, overflow=0, no_clock=0, busy drops the cycle after valid.
- mon_clk held 0, window=100, start -> after 1024 ARM cycles one valid pulse; no_clock=1, count=0, out_of_range=1.
- CNT_WIDTH=4, mon_clk period 4, window=100 -> count=15, overflow=1, out_of_range=1.
- Period 8, window=800, min=90/max=110 -> out_of_range=0; repeat with min=101 -> out_of_range=1; repeat with max=99 -> out_of_range=1.
- Second start mid-COUNT -> ignored, single valid, count=100; start with window=0 -> no busy, no valid, prior results unchanged.
- reset asserted for one cycle mid-COUNT -> next cycle all outputs 0, FSM IDLE, no valid; a new start then yields count=100.

Source files
------------

// File: rtl/clock_monitor.sv
// clock_monitor: measures a divided monitor clock by counting its synchronized
// rising edges over a programmable window of core_clk cycles, and flags a
// missing clock, counter saturation and results outside [min_count, max_count].
//
// Ports:
//   core_clk, reset           block clock, synchronous active-high reset
//   start                     single-cycle measurement request (ignored while busy or window==0)
//   mon_clk                   monitored clock, asynchronous to core_clk
//   window                    window length in core_clk cycles (latched on start)
//   min_count, max_count      inclusive acceptable bounds, sampled in DONE
//   count                     rising edges counted in the last window
//   valid                     one-cycle pulse while a result is published (DONE)
//   busy                      high from accepted start through DONE
//   overflow                  counter saturated during the last measurement
//   no_clock                  last measurement timed out waiting for an arming edge
//   out_of_range              overflow | no_clock | count below/above bounds
module clock_monitor #(
    parameter int CNT_WIDTH   = 16,
    parameter int WIN_WIDTH   = 16,
    parameter int ARM_TIMEOUT = 1024
) (
    input  logic                 core_clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mon_clk,
    input  logic [WIN_WIDTH-1:0] window,
    input  logic [CNT_WIDTH-1:0] min_count,
    input  logic [CNT_WIDTH-1:0] max_count,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 valid,
    output logic                 busy,
    output logic                 overflow,
    output logic                 no_clock,
    output logic                 out_of_range
);

    localparam int ARM_W = $clog2(ARM_TIMEOUT + 1);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    logic s1, s2, s3;
    logic mon_edge;

    logic [WIN_WIDTH-1:0] win_lat;
    logic [WIN_WIDTH-1:0] win_timer;
    logic [ARM_W-1:0]     arm_timer;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 ovf_int;

    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 ovf_next;
    logic                 range_bad;
    logic                 oor_reg;

    assign mon_edge = s2 & ~s3;

    always_ff @(posedge core_clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= mon_clk;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Saturating increment; an edge arriving at all-ones only raises the flag.
    always_comb begin
        cnt_next = cnt;
        ovf_next = ovf_int;
        if (mon_edge) begin
            if (&cnt) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt + CNT_WIDTH'(1);
            end
        end
    end

    // The range compare uses the bounds present during DONE, so it is evaluated
    // live in that cycle and frozen into oor_reg for the idle period after it.
    assign range_bad    = overflow | no_clock | (count < min_count) | (count > max_count);
    assign out_of_range = (state == DONE) ? range_bad : oor_reg;

    always_ff @(posedge core_clk) begin
        if (reset) begin
            state     <= IDLE;
            win_lat   <= '0;
            win_timer <= '0;
            arm_timer <= '0;
            cnt       <= '0;
            ovf_int   <= 1'b0;
            count     <= '0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            no_clock  <= 1'b0;
            oor_reg   <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (window != '0)) begin
                        win_lat   <= window;
                        cnt       <= '0;
                        ovf_int   <= 1'b0;
                        arm_timer <= '0;
                        busy      <= 1'b1;
                        state     <= ARM;
                    end
                end

                // Wait for a monitored edge so the window starts phase-aligned;
                // the arming edge itself is not counted.
                ARM: begin
                    arm_timer <= arm_timer + ARM_W'(1);
                    if (mon_edge) begin
                        win_timer <= win_lat;
                        state     <= COUNT;
                    end else if (arm_timer == ARM_LAST) begin
                        count    <= '0;
                        overflow <= 1'b0;
                        no_clock <= 1'b1;
                        valid    <= 1'b1;
                        state    <= DONE;
                    end
                end

                // Publish cnt_next on the last cycle so an edge there is included.
                COUNT: begin
                    win_timer <= win_timer - WIN_WIDTH'(1);
                    cnt       <= cnt_next;
                    ovf_int   <= ovf_next;
                    if (win_timer == WIN_WIDTH'(1)) begin
                        count    <= cnt_next;
                        overflow <= ovf_next;
                        no_clock <= 1'b0;
                        valid    <= 1'b1;
                        state    <= DONE;
                    end
                end

                DONE: begin
                    oor_reg <= range_bad;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_monitor.sv
module tb_clock_monitor;

    logic        core_clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mon_clk;
    logic [15:0] window;
    logic [15:0] min_count;
    logic [15:0] max_count;
    logic [3:0]  min4;
    logic [3:0]  max4;

    logic [15:0] count16;
    logic        valid16, busy16, ovf16, noclk16, oor16;
    logic [3:0]  count4;
    logic        valid4, busy4, ovf4, noclk4, oor4;

    clock_monitor dut16 (
        .core_clk(core_clk), .reset(reset), .start(start), .mon_clk(mon_clk),
        .window(window), .min_count(min_count), .max_count(max_count),
        .count(count16), .valid(valid16), .busy(busy16), .overflow(ovf16),
        .no_clock(noclk16), .out_of_range(oor16)
    );

    clock_monitor #(.CNT_WIDTH(4)) dut4 (
        .core_clk(core_clk), .reset(reset), .start(start), .mon_clk(mon_clk),
        .window(window), .min_count(min4), .max_count(max4),
        .count(count4), .valid(valid4), .busy(busy4), .overflow(ovf4),
        .no_clock(noclk4), .out_of_range(oor4)
    );

    always #5 core_clk = ~core_clk;

    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    int vcount   = 0;
    int vcyc     = 0;
    int rise_cyc = 0;
    int per_g    = 8;
    int ph       = 0;
    bit mon_en   = 1'b0;
    bit rise_pending = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One core_clk cycle: sample outputs at the falling edge, then drive mon_clk
    // as a clock of per_g cycles that rises on the first enabled falling edge.
    task automatic step();
        @(negedge core_clk);
        if (valid16) begin
            vcount++;
            vcyc = cyc;
        end
        if (mon_en) begin
            mon_clk = (ph < per_g / 2);
            if (ph == 0 && rise_pending) begin
                rise_cyc = cyc;
                rise_pending = 1'b0;
            end
            ph = (ph + 1) % per_g;
        end else begin
            mon_clk = 1'b0;
            ph = 0;
        end
    endtask

    // Reference: edges rise every per cycles after the arming rise; the window
    // holds win/per of them. The result appears win+3 cycles after the arming
    // rise (3-cycle synchronizer latency into the FSM plus the window).
    task automatic run_meas(input string tag, input int win, input int per,
                            input int mn, input int mx, input bit mid_start);
        int e, e16, e4, n;
        bit o16, o4, oor_exp;
        window = win; min_count = mn; max_count = mx; per_g = per;
        vcount = 0;
        step(); start = 1'b1;
        step(); start = 1'b0;
        repeat ($urandom_range(1, 6)) step();
        mon_en = 1'b1; rise_pending = 1'b1;
        n = 0;
        while (vcount == 0 && n < win + 200) begin
            step();
            n++;
            if (mid_start && n == win / 2) begin
                start = 1'b1;
                window = 16'd40;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        e   = win / per;
        o16 = (e > 65535);
        e16 = o16 ? 65535 : e;
        o4  = (e > 15);
        e4  = o4 ? 15 : e;
        oor_exp = o16 || (e16 < mn) || (e16 > mx);
        chk({tag, "_valid_seen"}, vcount, 1);
        chk({tag, "_latency"}, vcyc, rise_cyc + win + 3);
        chk({tag, "_count"}, count16, e16);
        chk({tag, "_overflow"}, ovf16, o16);
        chk({tag, "_no_clock"}, noclk16, 0);
        chk({tag, "_out_of_range"}, oor16, oor_exp);
        chk({tag, "_busy_in_done"}, busy16, 1);
        chk({tag, "_count4"}, count4, e4);
        chk({tag, "_overflow4"}, ovf4, o4);
        chk({tag, "_out_of_range4"}, oor4, o4);
        step();
        chk({tag, "_busy_drop"}, busy16, 0);
        chk({tag, "_valid_pulse"}, valid16, 0);
        chk({tag, "_oor_hold"}, oor16, oor_exp);
        repeat (5) step();
        chk({tag, "_single_valid"}, vcount, 1);
        mon_en = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        int c, n, e, per, win, mn, mx;
        bit busy_seen;
        reset = 1'b1; start = 1'b0; mon_clk = 1'b0;
        window = '0; min_count = '0; max_count = 16'hFFFF;
        min4 = 4'd0; max4 = 4'hF;

        repeat (3) step();
        chk("rst_count", count16, 0);
        chk("rst_valid", valid16, 0);
        chk("rst_busy", busy16, 0);
        chk("rst_overflow", ovf16, 0);
        chk("rst_no_clock", noclk16, 0);
        chk("rst_oor", oor16, 0);
        reset = 1'b0;
        repeat (2) step();

        run_meas("p8_w800_inrange", 800, 8, 90, 110, 1'b0);
        run_meas("p8_w800_min101", 800, 8, 101, 110, 1'b0);
        run_meas("p8_w800_max99", 800, 8, 90, 99, 1'b0);
        run_meas("p4_w100_sat", 100, 4, 0, 65535, 1'b0);

        // window==0 start is ignored and prior results hold
        window = '0; vcount = 0; busy_seen = 1'b0;
        step(); start = 1'b1;
        step(); start = 1'b0;
        if (busy16) busy_seen = 1'b1;
        repeat (10) begin
            step();
            if (busy16) busy_seen = 1'b1;
        end
        chk("win0_busy", busy_seen, 0);
        chk("win0_valid", vcount, 0);
        chk("win0_count_hold", count16, 25);
        chk("win0_ovf4_hold", ovf4, 1);
        chk("win0_oor4_hold", oor4, 1);

        run_meas("mid_start", 800, 8, 0, 65535, 1'b1);

        for (int t = 0; t < 4; t++) begin
            per = 2 * $urandom_range(2, 8);
            win = $urandom_range(20, 400);
            e   = win / per;
            mn  = $urandom_range(0, e + 3);
            mx  = $urandom_range((e > 3) ? e - 3 : 0, e + 10);
            run_meas($sformatf("rand%0d", t), win, per, mn, mx, 1'b0);
        end

        // no monitored clock: ARM times out
        mon_en = 1'b0; window = 16'd100; min_count = 0; max_count = 200;
        vcount = 0;
        step(); c = cyc; start = 1'b1;
        step(); start = 1'b0;
        n = 0;
        while (vcount == 0 && n < 1300) begin
            step();
            n++;
        end
        chk("noclk_valid_seen", vcount, 1);
        chk("noclk_latency", vcyc, c + 1025);
        chk("noclk_no_clock", noclk16, 1);
        chk("noclk_count", count16, 0);
        chk("noclk_overflow", ovf16, 0);
        chk("noclk_oor", oor16, 1);
        chk("noclk_no_clock4", noclk4, 1);
        chk("noclk_oor4", oor4, 1);
        step();
        chk("noclk_busy_drop", busy16, 0);
        repeat (5) step();
        chk("noclk_single_valid", vcount, 1);

        // reset mid-COUNT aborts without a valid pulse
        window = 16'd800; per_g = 8; min_count = 0; max_count = 16'hFFFF;
        vcount = 0;
        step(); start = 1'b1;
        step(); start = 1'b0;
        step(); mon_en = 1'b1; rise_pending = 1'b1;
        repeat (200) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_count", count16, 0);
        chk("midrst_valid", valid16, 0);
        chk("midrst_busy", busy16, 0);
        chk("midrst_overflow", ovf16, 0);
        chk("midrst_no_clock", noclk16, 0);
        chk("midrst_oor", oor16, 0);
        repeat (900) step();
        chk("midrst_no_valid", vcount, 0);
        chk("midrst_idle", busy16, 0);
        mon_en = 1'b0;
        repeat (4) step();

        run_meas("after_reset", 800, 8, 0, 65535, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
